button_event_decoder: RTL and testbench

Input-side counterpart to the board LED drivers on the iCEBreaker (iCE40-UP5K). It samples the on-board user button (BTN_N, active-low) and the three break-off buttons (BTN1..BTN3, active-high). Each button is synchronised and debounced, and the block emits a clean level plus single-cycle press, release and long-press events for downstream logic such as LED controllers. The four button channels are identical and independent.

---
 rtl/button_event_decoder.sv | 87 ++++++++
 tb/tb_button_event_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Synchronises, debounces and decodes the four iCEBreaker buttons into a clean
// pressed level plus single-cycle press, release and long-press events.
module button_event_decoder #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_N,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  output logic [3:0] PRESSED,
  output logic [3:0] PRESS_P,
  output logic [3:0] RELEASE_P,
  output logic [3:0] LONG_P
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HC_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HC_PRE  = HW'(LONG_CYCLES - 1);

  logic [3:0] raw;

  // Every channel is 1 = pressed from here on.
  assign raw = {BTN3, BTN2, BTN1, ~BTN_N};

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          pressed_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic [DW-1:0] dc;
    logic [HW-1:0] hc;

    always_ff @(posedge CLK) begin
      if (RST) begin
        sync1     <= 1'b0;
        sync2     <= 1'b0;
        stable    <= 1'b0;
        dc        <= '0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        hc        <= '0;
        long_q    <= 1'b0;
      end else begin
        sync1 <= raw[i];
        sync2 <= sync1;

        if (sync2 == stable) begin
          dc <= '0;
        end else if (dc == DC_LAST) begin
          stable <= sync2;
          dc     <= '0;
        end else begin
          dc <= dc + DW'(1);
        end

        // Level and edge pulses are registered together so they line up.
        pressed_q <= stable;
        press_q   <= stable & ~pressed_q;
        release_q <= ~stable & pressed_q;

        // Counter starts on the cycle after PRESS_P; gating on stable keeps a
        // release edge from ever carrying a long-press pulse.
        if (!stable || !pressed_q) begin
          hc <= '0;
        end else if (hc != HC_MAX) begin
          hc <= hc + HW'(1);
        end
        long_q <= stable & pressed_q & (hc == HC_PRE);
      end
    end

    assign PRESSED[i]   = pressed_q;
    assign PRESS_P[i]   = press_q;
    assign RELEASE_P[i] = release_q;
    assign LONG_P[i]    = long_q;
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed plus randomized bench for button_event_decoder, checked every cycle
// against a run-length / delay-line reference model.
module tb_button_event_decoder;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic       CLK;
  logic       RST;
  logic       BTN_N;
  logic       BTN1;
  logic       BTN2;
  logic       BTN3;
  logic [3:0] PRESSED;
  logic [3:0] PRESS_P;
  logic [3:0] RELEASE_P;
  logic [3:0] LONG_P;

  button_event_decoder #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN_N    (BTN_N),
    .BTN1     (BTN1),
    .BTN2     (BTN2),
    .BTN3     (BTN3),
    .PRESSED  (PRESSED),
    .PRESS_P  (PRESS_P),
    .RELEASE_P(RELEASE_P),
    .LONG_P   (LONG_P)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: accepted level from run length of raw samples, then a
  // fixed three-edge delay to the outputs (two sync stages + output register).
  logic [3:0] lvl, d0, d1, d2;
  logic [3:0] m_pressed, m_press, m_rel, m_long;
  int run [4];
  int held [4];

  int obs_press [4];
  int obs_rel [4];
  int obs_long [4];
  int press_cyc [4];
  int long_cyc [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] raw);
    logic [3:0] prev;
    if (rst) begin
      lvl = '0; d0 = '0; d1 = '0; d2 = '0;
      m_pressed = '0; m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < 4; i++) begin
        run[i]  = 0;
        held[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (raw[i] != lvl[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            lvl[i] = raw[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      prev      = m_pressed;
      m_pressed = d2;
      d2 = d1;
      d1 = d0;
      d0 = lvl;
      m_press = m_pressed & ~prev;
      m_rel   = ~m_pressed & prev;
      for (int i = 0; i < 4; i++) begin
        held[i]   = m_pressed[i] ? held[i] + 1 : 0;
        m_long[i] = (held[i] == LONG + 1);
      end
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) begin
      obs_press[i] = 0;
      obs_rel[i]   = 0;
      obs_long[i]  = 0;
      press_cyc[i] = -1;
      long_cyc[i]  = -1;
    end
  endtask

  task automatic step();
    logic [3:0] raw;
    @(posedge CLK);
    raw = {BTN3, BTN2, BTN1, ~BTN_N};
    model_edge(RST, raw);
    #1;
    chk("pressed", PRESSED, m_pressed);
    chk("press_p", PRESS_P, m_press);
    chk("release_p", RELEASE_P, m_rel);
    chk("long_p", LONG_P, m_long);
    for (int i = 0; i < 4; i++) begin
      if (PRESS_P[i]) begin
        obs_press[i]++;
        press_cyc[i] = cyc;
      end
      if (RELEASE_P[i]) obs_rel[i]++;
      if (LONG_P[i]) begin
        obs_long[i]++;
        long_cyc[i] = cyc;
      end
    end
    cyc++;
  endtask

  initial begin
    int p;
    RST = 1'b1; BTN_N = 1'b1; BTN1 = 1'b0; BTN2 = 1'b0; BTN3 = 1'b0;
    clear_obs();

    // Power-on with BTN_N released: everything stays quiet.
    repeat (3) step();
    RST = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      chk("t6_idle", {PRESSED, PRESS_P, RELEASE_P, LONG_P}, 16'h0000);
    end

    // Clean press and release on BTN1.
    clear_obs();
    BTN1 = 1'b1;
    step();
    repeat (5) step();
    chk("t1_early", PRESSED, 4'b0000);
    step();
    chk("t1_press", PRESS_P, 4'b0010);
    chk("t1_level", PRESSED, 4'b0010);
    repeat (3) step();
    BTN1 = 1'b0;
    step();
    repeat (5) step();
    chk("t1_rel_early", RELEASE_P, 4'b0000);
    step();
    chk("t1_release", RELEASE_P, 4'b0010);
    step();
    chk("t1_rel_once", RELEASE_P, 4'b0000);
    chk("t1_nolong", obs_long[1], 0);

    // Bounce on BTN2 shorter than the debounce window.
    clear_obs();
    BTN2 = 1'b1; repeat (3) step();
    BTN2 = 1'b0; step();
    BTN2 = 1'b1; repeat (3) step();
    BTN2 = 1'b0; repeat (10) step();
    chk("t2_bounce_evt", obs_press[2] + obs_rel[2] + obs_long[2], 0);
    chk("t2_bounce_lvl", PRESSED, 4'b0000);
    BTN2 = 1'b1;
    step();
    repeat (5) step();
    step();
    chk("t2_press", PRESS_P, 4'b0100);
    BTN2 = 1'b0;
    repeat (10) step();

    // Long press on the on-board button.
    clear_obs();
    BTN_N = 1'b0;
    repeat (40) step();
    chk("t3_press_cnt", obs_press[0], 1);
    chk("t3_long_cnt", obs_long[0], 1);
    chk("t3_long_dist", long_cyc[0] - press_cyc[0], LONG);
    BTN_N = 1'b1;
    repeat (10) step();
    chk("t3_rel_cnt", obs_rel[0], 1);
    chk("t3_long_after", obs_long[0], 1);

    // BTN1 and BTN3 together, then independent release / long press.
    clear_obs();
    BTN1 = 1'b1; BTN3 = 1'b1;
    step();
    repeat (5) step();
    step();
    chk("t4_press", PRESS_P, 4'b1010);
    repeat (3) step();
    BTN1 = 1'b0;
    repeat (30) step();
    chk("t4_rel1", obs_rel[1], 1);
    chk("t4_long3", obs_long[3], 1);
    chk("t4_long1", obs_long[1], 0);
    chk("t4_rel3", obs_rel[3], 0);
    BTN3 = 1'b0;
    repeat (10) step();

    // Reset in the middle of a held press.
    clear_obs();
    BTN2 = 1'b1;
    repeat (7) step();
    chk("t5_held", PRESSED, 4'b0100);
    RST = 1'b1;
    step();
    chk("t5_rst_lvl", PRESSED, 4'b0000);
    chk("t5_rst_rel", RELEASE_P, 4'b0000);
    RST = 1'b0;
    step();
    repeat (5) step();
    step();
    chk("t5_repress", PRESS_P, 4'b0100);
    chk("t5_no_rel", obs_rel[2], 0);
    BTN2 = 1'b0;
    repeat (10) step();

    // Randomized activity with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      p = (k < 2000) ? 12 : 5;
      if ($urandom_range(0, p - 1) == 0) BTN_N = ~BTN_N;
      if ($urandom_range(0, p - 1) == 0) BTN1 = ~BTN1;
      if ($urandom_range(0, p - 1) == 0) BTN2 = ~BTN2;
      if ($urandom_range(0, p - 1) == 0) BTN3 = ~BTN3;
      RST = ($urandom_range(0, 399) == 0);
      step();
    end
    RST = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
